dac_table_8x_deadlock_reporter: RTL and testbench

Consumer of the deadlock monitor's `block` output in the `dac_table_8x` design. It qualifies a raw deadlock indication by requiring it to persist for a programmable number of cycles. Once qualified, it latches a snapshot of the AXIS and instance blocking/idle vectors together with a timestamp, and raises a sticky interrupt. It then runs an ack handshake with the control/PS side and re-arms only after the deadlock condition has cleared.

---
 rtl/dac_table_8x_deadlock_pkg.sv | 30 +++
 rtl/dac_table_8x_deadlock_persist_cnt.sv | 43 ++++
 rtl/dac_table_8x_deadlock_reporter.sv | 159 +++++++++++++++
 tb/tb_dac_table_8x_deadlock_reporter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_table_8x_deadlock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_table_8x_deadlock_pkg
// Purpose  : Shared types and widths for the dac_table_8x deadlock reporter:
//            the reporter state encoding, the widths of the captured
//            blocking/idle vectors, and the packed snapshot record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dac_table_8x_deadlock_pkg;

    localparam int DL_AXIS_W = 3;
    localparam int DL_IDLE_W = 2;
    localparam int DL_INST_W = 1;

    typedef enum logic [1:0] {
        DL_IDLE       = 2'd0,
        DL_COUNT      = 2'd1,
        DL_LATCHED    = 2'd2,
        DL_WAIT_CLEAR = 2'd3
    } dl_state_t;

    typedef struct packed {
        logic [DL_AXIS_W-1:0] axis;
        logic [DL_IDLE_W-1:0] idle;
        logic [DL_INST_W-1:0] inst;
    } dl_snap_t;

endpackage
`default_nettype wire

// File: rtl/dac_table_8x_deadlock_persist_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dac_table_8x_deadlock_persist_cnt
// Purpose  : Persistence counter for the deadlock reporter. Counts cycles of
//            a sustained block indication; hit flags the last count before
//            the report threshold.
// Ports    : ap_clk   - clock
//            ap_rst_n - asynchronous active-low reset
//            inc      - advance the count by one
//            clr      - return the count to zero (wins over inc)
//            hit      - count equals PERSIST_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
module dac_table_8x_deadlock_persist_cnt #(
    parameter int unsigned PERSIST_CYCLES = 16
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    // 16 bits covers the full legal PERSIST_CYCLES range of 1..65535.
    localparam int               CNT_W     = 16;
    localparam logic [CNT_W-1:0] c_hit_val = CNT_W'(PERSIST_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hit = (r_cnt == c_hit_val);

endmodule
`default_nettype wire

// File: rtl/dac_table_8x_deadlock_reporter.sv
`default_nettype none
// ============================================================================
// Module   : dac_table_8x_deadlock_reporter
// Purpose  : Qualifies the deadlock monitor's block indication by requiring it
//            to persist PERSIST_CYCLES cycles, then captures the blocking/idle
//            vectors plus a timestamp, raises a sticky irq, waits for ack and
//            re-arms only once block has dropped.
// Ports    : ap_clk          - sole clock
//            ap_rst_n        - asynchronous active-low reset
//            block           - raw deadlock indication
//            axis_block_sigs - per-AXIS-channel blocking flags
//            inst_idle_sigs  - sub-instance idle flags
//            inst_block_sigs - sub-instance block flag
//            ack             - report acknowledge (level)
//            irq             - sticky report pending
//            snap_axis/idle/inst - vectors captured at report time
//            snap_time       - timestamp captured at report time
//            event_count     - saturating number of reports issued
//            armed           - reporter is in IDLE or COUNT
// Revision : 1.0 - initial release
// ============================================================================
module dac_table_8x_deadlock_reporter
    import dac_table_8x_deadlock_pkg::*;
#(
    parameter int unsigned PERSIST_CYCLES = 16,
    parameter int unsigned TS_W           = 32,
    parameter int unsigned EVT_W          = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 block,
    input  logic [DL_AXIS_W-1:0] axis_block_sigs,
    input  logic [DL_IDLE_W-1:0] inst_idle_sigs,
    input  logic [DL_INST_W-1:0] inst_block_sigs,
    input  logic                 ack,
    output logic                 irq,
    output logic [DL_AXIS_W-1:0] snap_axis,
    output logic [DL_IDLE_W-1:0] snap_idle,
    output logic [DL_INST_W-1:0] snap_inst,
    output logic [TS_W-1:0]      snap_time,
    output logic [EVT_W-1:0]     event_count,
    output logic                 armed
);

    dl_state_t        r_state;
    dl_state_t        w_next;
    logic             w_inc;
    logic             w_clr;
    logic             w_capture;
    logic             w_hit;
    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_snap_time;
    logic [EVT_W-1:0] r_evt;
    dl_snap_t         r_snap;
    logic             r_irq;
    logic             r_armed;

    dac_table_8x_deadlock_persist_cnt #(
        .PERSIST_CYCLES (PERSIST_CYCLES)
    ) u_persist_cnt (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .inc      (w_inc),
        .clr      (w_clr),
        .hit      (w_hit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= DL_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_inc     = 1'b0;
        w_clr     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            DL_IDLE: begin
                if (block) begin
                    if (PERSIST_CYCLES == 1) begin
                        w_next    = DL_LATCHED;
                        w_capture = 1'b1;
                    end else begin
                        w_next = DL_COUNT;
                        w_inc  = 1'b1;
                    end
                end
            end
            DL_COUNT: begin
                if (!block) begin
                    w_next = DL_IDLE;
                    w_clr  = 1'b1;
                end else if (w_hit) begin
                    // Clear now so the next qualification starts from zero.
                    w_next    = DL_LATCHED;
                    w_capture = 1'b1;
                    w_clr     = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            DL_LATCHED: begin
                if (ack) begin
                    w_next = block ? DL_WAIT_CLEAR : DL_IDLE;
                end
            end
            DL_WAIT_CLEAR: begin
                // Hold off re-arming until the deadlock has actually gone
                // away, otherwise a stuck block would re-report continuously.
                if (!block) begin
                    w_next = DL_IDLE;
                end
            end
            default: begin
                w_next = DL_IDLE;
            end
        endcase
    end

    // irq and armed decode the next state so they move on the same edge as
    // the state register while still being driven from flops.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ts        <= '0;
            r_snap      <= '0;
            r_snap_time <= '0;
            r_evt       <= '0;
            r_irq       <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_ts    <= r_ts + 1'b1;
            r_irq   <= (w_next == DL_LATCHED);
            r_armed <= (w_next == DL_IDLE) || (w_next == DL_COUNT);
            if (w_capture) begin
                r_snap.axis <= axis_block_sigs;
                r_snap.idle <= inst_idle_sigs;
                r_snap.inst <= inst_block_sigs;
                r_snap_time <= r_ts;
                if (r_evt != {EVT_W{1'b1}}) begin
                    r_evt <= r_evt + 1'b1;
                end
            end
        end
    end

    assign irq         = r_irq;
    assign armed       = r_armed;
    assign snap_axis   = r_snap.axis;
    assign snap_idle   = r_snap.idle;
    assign snap_inst   = r_snap.inst;
    assign snap_time   = r_snap_time;
    assign event_count = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_dac_table_8x_deadlock_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_table_8x_deadlock_reporter
// Purpose  : Self-checking bench. Instance A uses default parameters; instance
//            B uses PERSIST_CYCLES=1 with narrow timestamp/event widths to
//            reach the wrap and saturation boundaries quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_table_8x_deadlock_reporter;

    logic       ap_clk = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic       block = 1'b0;
    logic       ack = 1'b0;
    logic [2:0] axis_in = '0;
    logic [1:0] idle_in = '0;
    logic [0:0] inst_in = '0;

    logic        irq_a, armed_a, irq_b, armed_b;
    logic [2:0]  sa_a, sa_b;
    logic [1:0]  si_a, si_b;
    logic [0:0]  sn_a, sn_b;
    logic [31:0] st_a;
    logic [3:0]  st_b;
    logic [15:0] evt_a;
    logic [1:0]  evt_b;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    always #5 ap_clk = ~ap_clk;

    dac_table_8x_deadlock_reporter u_dut_a (
        .ap_clk (ap_clk), .ap_rst_n (rst_a_n), .block (block),
        .axis_block_sigs (axis_in), .inst_idle_sigs (idle_in),
        .inst_block_sigs (inst_in), .ack (ack), .irq (irq_a),
        .snap_axis (sa_a), .snap_idle (si_a), .snap_inst (sn_a),
        .snap_time (st_a), .event_count (evt_a), .armed (armed_a)
    );

    dac_table_8x_deadlock_reporter #(
        .PERSIST_CYCLES (1), .TS_W (4), .EVT_W (2)
    ) u_dut_b (
        .ap_clk (ap_clk), .ap_rst_n (rst_b_n), .block (block),
        .axis_block_sigs (axis_in), .inst_idle_sigs (idle_in),
        .inst_block_sigs (inst_in), .ack (ack), .irq (irq_b),
        .snap_axis (sa_b), .snap_idle (si_b), .snap_inst (sn_b),
        .snap_time (st_b), .event_count (evt_b), .armed (armed_b)
    );

    // Behavioural reference: tracks the run length of consecutive block
    // samples while armed, a pending report, and a must-see-clear flag.
    typedef struct {
        bit         irq;
        bit         armed;
        bit         need_clear;
        int         run;
        int         evt;
        logic [2:0] sa;
        logic [1:0] si;
        logic [0:0] sn;
        longint     ts;
        longint     st;
    } mdl_t;

    typedef struct {
        int         dut;
        bit         irq;
        bit         armed;
        int         evt;
        logic [2:0] sa;
        logic [1:0] si;
        logic [0:0] sn;
        longint     st;
    } exp_t;

    typedef struct {
        int         n;
        bit         b;
        bit         a;
        logic [2:0] ax;
        bit         e_irq;
        bit         e_armed;
        int         e_evt;
        bit         chk_snap;
        logic [2:0] e_ax;
        int         e_time;
    } vec_t;

    mdl_t m_a, m_b;
    exp_t sb[$];
    vec_t tbl[16];

    function automatic mdl_t mreset();
        mdl_t m;
        m.irq = 0; m.armed = 1; m.need_clear = 0; m.run = 0; m.evt = 0;
        m.sa = '0; m.si = '0; m.sn = '0; m.ts = 0; m.st = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit b, bit a, logic [2:0] ax,
                                   logic [1:0] id, logic [0:0] isn,
                                   int p, int evt_max, longint ts_mod);
        mdl_t n = m;
        if (m.irq) begin
            if (a) begin
                n.irq = 0;
                n.need_clear = b;
            end
        end else if (m.need_clear) begin
            if (!b) n.need_clear = 0;
        end else if (b) begin
            n.run = m.run + 1;
            if (n.run == p) begin
                n.run = 0;
                n.irq = 1;
                n.sa = ax; n.si = id; n.sn = isn;
                n.st = m.ts;
                if (m.evt < evt_max) n.evt = m.evt + 1;
            end
        end else begin
            n.run = 0;
        end
        n.armed = !n.irq && !n.need_clear;
        n.ts = (m.ts + 1) % ts_mod;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge), advance
    // the reference at the rising edge and queue what the DUT must show.
    task automatic step(input bit b, input bit a, input logic [2:0] ax);
        exp_t e;
        block = b; ack = a; axis_in = ax; idle_in = ax[1:0]; inst_in = ax[2];
        @(posedge ap_clk);
        if (cur == 0) begin
            m_a = mstep(m_a, b, a, ax, ax[1:0], ax[2], 16, 65535, 64'sh1_0000_0000);
            e = '{0, m_a.irq, m_a.armed, m_a.evt, m_a.sa, m_a.si, m_a.sn, m_a.st};
        end else begin
            m_b = mstep(m_b, b, a, ax, ax[1:0], ax[2], 1, 3, 16);
            e = '{1, m_b.irq, m_b.armed, m_b.evt, m_b.sa, m_b.si, m_b.sn, m_b.st};
        end
        sb.push_back(e);
        @(negedge ap_clk);
    endtask

    always @(negedge ap_clk) begin : mon
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                chk("sb_irq_a",   irq_a,   e.irq);
                chk("sb_armed_a", armed_a, e.armed);
                chk("sb_evt_a",   evt_a,   e.evt);
                chk("sb_snap_a",  {sa_a, si_a, sn_a}, {e.sa, e.si, e.sn});
                chk("sb_time_a",  st_a,    e.st);
            end else begin
                chk("sb_irq_b",   irq_b,   e.irq);
                chk("sb_armed_b", armed_b, e.armed);
                chk("sb_evt_b",   evt_b,   e.evt);
                chk("sb_snap_b",  {sa_b, si_b, sn_b}, {e.sa, e.si, e.sn});
                chk("sb_time_b",  st_b,    e.st);
            end
        end
    end

    task automatic chk_reset_a(input string tag);
        chk({tag, "_irq"},   irq_a,   0);
        chk({tag, "_armed"}, armed_a, 1);
        chk({tag, "_evt"},   evt_a,   0);
        chk({tag, "_snap"},  {sa_a, si_a, sn_a}, 0);
        chk({tag, "_time"},  st_a,    0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        //        n   b  a  ax      irq armed evt chk e_ax    e_time
        tbl[0]  = '{10, 0, 0, 3'b000, 0, 1, 0, 0, 3'b000, 0};
        tbl[1]  = '{15, 1, 0, 3'b101, 0, 1, 0, 0, 3'b000, 0};
        tbl[2]  = '{1,  1, 0, 3'b101, 1, 0, 1, 1, 3'b101, 25};
        tbl[3]  = '{2,  1, 0, 3'b101, 1, 0, 1, 0, 3'b000, 0};
        tbl[4]  = '{1,  1, 1, 3'b101, 0, 0, 1, 0, 3'b000, 0};
        tbl[5]  = '{20, 1, 0, 3'b101, 0, 0, 1, 0, 3'b000, 0};
        tbl[6]  = '{1,  0, 0, 3'b000, 0, 1, 1, 0, 3'b000, 0};
        tbl[7]  = '{15, 1, 0, 3'b011, 0, 1, 1, 0, 3'b000, 0};
        tbl[8]  = '{1,  0, 0, 3'b011, 0, 1, 1, 0, 3'b000, 0};
        tbl[9]  = '{15, 1, 0, 3'b010, 0, 1, 1, 0, 3'b000, 0};
        tbl[10] = '{1,  1, 0, 3'b010, 1, 0, 2, 1, 3'b010, 81};
        tbl[11] = '{1,  0, 1, 3'b000, 0, 1, 2, 1, 3'b010, 81};
        tbl[12] = '{15, 1, 0, 3'b111, 0, 1, 2, 0, 3'b000, 0};
        tbl[13] = '{1,  1, 1, 3'b111, 1, 0, 3, 1, 3'b111, 98};
        tbl[14] = '{1,  0, 0, 3'b111, 1, 0, 3, 0, 3'b000, 0};
        tbl[15] = '{1,  0, 1, 3'b000, 0, 1, 3, 0, 3'b000, 0};

        m_a = mreset();
        m_b = mreset();
        repeat (3) @(negedge ap_clk);
        chk_reset_a("reset_init");
        rst_a_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < tbl[i].n; c++) step(tbl[i].b, tbl[i].a, tbl[i].ax);
            chk($sformatf("vec%0d_irq", i),   irq_a,   tbl[i].e_irq);
            chk($sformatf("vec%0d_armed", i), armed_a, tbl[i].e_armed);
            chk($sformatf("vec%0d_evt", i),   evt_a,   tbl[i].e_evt);
            if (tbl[i].chk_snap) begin
                chk($sformatf("vec%0d_snap_axis", i), sa_a, tbl[i].e_ax);
                chk($sformatf("vec%0d_snap_time", i), st_a, tbl[i].e_time);
            end
        end

        // Reset in the middle of COUNT: asynchronous, partial run discarded.
        for (int c = 0; c < 8; c++) step(1, 0, 3'b001);
        #2 rst_a_n = 1'b0;
        m_a = mreset();
        #1 chk_reset_a("rst_count");
        @(negedge ap_clk);
        @(negedge ap_clk);
        rst_a_n = 1'b1;
        for (int c = 0; c < 15; c++) step(1, 0, 3'b001);
        chk("rst_count_no_early_irq", irq_a, 0);
        step(1, 0, 3'b001);
        chk("rst_count_full_irq", irq_a, 1);
        chk("rst_count_evt", evt_a, 1);
        chk("rst_count_time", st_a, 15);

        // Reset while LATCHED.
        #2 rst_a_n = 1'b0;
        m_a = mreset();
        #1 chk_reset_a("rst_latched");
        @(negedge ap_clk);
        rst_a_n = 1'b1;
        block = 1'b0;
        for (int c = 0; c < 3; c++) step(0, 0, 3'b000);

        // Instance B: single-cycle persistence, 2-bit events, 4-bit timestamp.
        cur = 1;
        @(negedge ap_clk);
        rst_b_n = 1'b1;
        step(0, 0, 3'b000);
        step(1, 0, 3'b110);
        chk("p1_irq", irq_b, 1);
        chk("p1_armed", armed_b, 0);
        chk("p1_evt", evt_b, 1);
        chk("p1_time", st_b, 1);
        step(0, 1, 3'b000);
        chk("p1_ack_irq", irq_b, 0);
        for (int r = 0; r < 4; r++) begin
            step(1, 0, 3'(r));
            step(0, 1, 3'b000);
        end
        chk("evt_saturated", evt_b, 3);
        for (int c = 0; c < 5; c++) step(0, 0, 3'b000);
        step(1, 0, 3'b011);
        chk("ts_wrap_irq", irq_b, 1);
        chk("ts_wrap_time", st_b, 0);
        chk("ts_wrap_evt_sat", evt_b, 3);
        step(0, 1, 3'b000);

        @(negedge ap_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
